// File: rtl/multiword_add_ctrl.sv
// Two-requester multi-byte adder: one shared 8-bit ripple stage walks the
// operands a byte per cycle, with alternating arbitration and a held result.
module multiword_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [8*WORDS-1:0]   req0_a,
    input  logic [8*WORDS-1:0]   req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [8*WORDS-1:0]   req1_a,
    input  logic [8*WORDS-1:0]   req1_b,
    input  logic                 req1_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [8*WORDS-1:0]   rsp_sum,
    output logic                 rsp_cout,
    output logic                 busy
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic                   carry;
    logic                   last_grant;
    logic                   gnt;
    logic                   accept;
    logic                   id_q;
    logic [WORDS-1:0][7:0]  a_q;
    logic [WORDS-1:0][7:0]  b_q;
    logic [WORDS-1:0][7:0]  sum_q;
    logic [WORDS-1:0][7:0]  sum_nxt;
    logic [8:0]             byte_s;

    function automatic logic [8:0] add_byte(input logic [7:0] x, input logic [7:0] y,
                                            input logic c);
        return {1'b0, x} + {1'b0, y} + {8'b0, c};
    endfunction

    // Alternate only on a genuine contest; a lone requester always wins.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid)
            gnt = ~last_grant;
        else if (req1_valid)
            gnt = 1'b1;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !gnt;
    assign req1_ready = (state == IDLE) && req1_valid && gnt;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    assign byte_s = add_byte(a_q[idx], b_q[idx], carry);

    always_comb begin
        sum_nxt      = sum_q;
        sum_nxt[idx] = byte_s[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            carry      <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx        <= '0;
                        carry      <= gnt ? req1_cin : req0_cin;
                        last_grant <= gnt;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    carry <= byte_s[8];
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_sum   <= sum_nxt;
                        rsp_cout  <= byte_s[8];
                        rsp_id    <= id_q;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and partial-sum storage; only meaningful once a request is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= gnt ? req1_a : req0_a;
            b_q  <= gnt ? req1_b : req0_b;
            id_q <= gnt;
        end else if (state == ADD) begin
            sum_q <= sum_nxt;
        end
    end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Bench for multiword_add_ctrl: vector table, random transactions against an
// arithmetic model, arbitration fairness, backpressure and mid-operation reset.
module tb_multiword_add_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_cin = 1'b0, req1_cin = 1'b0;
    logic         rsp_valid, rsp_id, rsp_cout, busy;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multiword_add_ctrl #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        int           hold;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic scramble();
        req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 back in idle.
    task automatic run_txn(input string tag, input logic id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin, input int hold,
                           input logic [W-1:0] esum, input logic ecout);
        int lat;
        scramble();
        rsp_ready = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
        #1;
        chk({tag, " ready_own"},   id ? req1_ready : req0_ready, 1);
        chk({tag, " ready_other"}, id ? req0_ready : req1_ready, 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        scramble();
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, lat, WORDS);
        chk({tag, " sum"},  rsp_sum, esum);
        chk({tag, " cout"}, rsp_cout, ecout);
        chk({tag, " id"},   rsp_id, id);
        chk({tag, " busy"}, busy, 1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, " bp_valid"}, rsp_valid, 1);
            chk({tag, " bp_sum"},   {rsp_id, rsp_cout, rsp_sum}, {id, ecout, esum});
            chk({tag, " bp_ready"}, {req0_ready, req1_ready}, 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, " idle"}, {busy, rsp_valid}, 0);
        chk({tag, " held"}, {rsp_cout, rsp_sum}, {ecout, esum});
    endtask

    initial begin
        logic [W:0] full;
        logic [W:0] exp0, exp1;
        int gid[$];
        int gcyc[$];
        int pend[$];
        int seen;

        vecs[0] = '{id: 1'b0, a: 32'h000000FF, b: 32'h00000001, cin: 1'b0, hold: 0, sum: 32'h00000100, cout: 1'b0};
        vecs[1] = '{id: 1'b1, a: 32'hFFFFFFFF, b: 32'h00000000, cin: 1'b1, hold: 0, sum: 32'h00000000, cout: 1'b1};
        vecs[2] = '{id: 1'b0, a: 32'h80000000, b: 32'h80000000, cin: 1'b0, hold: 3, sum: 32'h00000000, cout: 1'b1};
        vecs[3] = '{id: 1'b1, a: 32'h12345678, b: 32'h11111111, cin: 1'b0, hold: 1, sum: 32'h23456789, cout: 1'b0};
        vecs[4] = '{id: 1'b0, a: 32'h7FFFFFFF, b: 32'h00000000, cin: 1'b1, hold: 0, sum: 32'h80000000, cout: 1'b0};
        vecs[5] = '{id: 1'b1, a: 32'h00FF00FF, b: 32'h00010001, cin: 1'b0, hold: 2, sum: 32'h01000100, cout: 1'b0};

        do_reset();
        chk("reset outputs", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, 0);
        chk("reset busy", busy, 0);
        chk("reset ready", {req0_ready, req1_ready}, 0);

        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].hold, vecs[i].sum, vecs[i].cout);

        for (int i = 0; i < 20; i++) begin
            logic         rid, rcin;
            logic [W-1:0] ra, rb;
            rid  = 1'($urandom);
            ra   = (i % 5 == 0) ? '1 : W'($urandom);
            rb   = W'($urandom);
            rcin = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + (W+1)'(rcin);
            run_txn($sformatf("rnd%0d", i), rid, ra, rb, rcin, $urandom_range(0, 2),
                    full[W-1:0], full[W]);
        end

        // Fairness: both requesters hold valid with fixed operands.
        do_reset();
        req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'b1;
        req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'b0;
        exp0 = {1'b0, req0_a} + {1'b0, req0_b} + (W+1)'(1);
        exp1 = {1'b0, req1_a} + {1'b0, req1_b};
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        seen = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (req0_ready) begin gid.push_back(0); gcyc.push_back(cyc); pend.push_back(0); end
            if (req1_ready) begin gid.push_back(1); gcyc.push_back(cyc); pend.push_back(1); end
            if (rsp_valid) begin
                seen++;
                if (pend.size() == 0) begin
                    chk("fair spurious rsp", 1, 0);
                end else begin
                    chk("fair rsp id", rsp_id, pend[0]);
                    chk("fair rsp sum", {rsp_cout, rsp_sum}, pend[0] == 1 ? exp1 : exp0);
                    void'(pend.pop_front());
                end
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("fair grant count", gid.size() >= 4, 1);
        chk("fair rsp count", seen >= 4, 1);
        for (int i = 0; i < 4 && i < gid.size(); i++)
            chk($sformatf("fair order%0d", i), gid[i], i % 2);
        for (int i = 1; i < 4 && i < gcyc.size(); i++)
            chk($sformatf("fair spacing%0d", i), gcyc[i] - gcyc[i-1], WORDS + 2);
        repeat (8) step();

        // Mid-operation reset while byte 2 is in the adder.
        run_txn("pre", 1'b1, 32'hDEADBEEF, 32'h01010101, 1'b1, 0, 32'hDFAEBFF1, 1'b0);
        req0_valid = 1'b1; req0_a = 32'hAAAAAAAA; req0_b = 32'h55555555; req0_cin = 1'b1;
        step();
        req0_valid = 1'b0;
        step();
        step();
        chk("midrst busy before", busy, 1);
        rst_n = 1'b0;
        #2;
        chk("midrst outputs", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, 0);
        chk("midrst busy", busy, 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid || busy) seen++;
        end
        chk("midrst no response", seen, 0);
        run_txn("post", 1'b0, 32'h12345678, 32'h11111111, 1'b0, 0, 32'h23456789, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
